// File: rtl/doodle_pkg.sv
// Shared constants, state encoding and initial platform layout for the platform scroller.
package doodle_pkg;

    localparam int NUM_PLAT   = 16;
    localparam int Y_LIMIT    = 480;
    localparam int MAX_SCROLL = 63;
    localparam int PLAT_X_MIN = 32;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCROLL,
        DONE
    } scroll_state_t;

    function automatic logic [8:0] init_x(input logic [3:0] i);
        return 9'(64 + 24 * int'(i));
    endfunction

    function automatic logic [8:0] init_y(input logic [3:0] i);
        return 9'(464 - 29 * int'(i));
    endfunction

endpackage

// File: rtl/plat_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying respawn X positions.
module plat_lfsr
    import doodle_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] out
);

    logic feedback;

    assign feedback = out[15] ^ out[13] ^ out[12] ^ out[10];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) out <= LFSR_SEED;
        else       out <= {out[14:0], feedback};
    end

endmodule

// File: rtl/platform_scroller.sv
// Owns the 16-entry platform table: reloads the initial layout and scrolls/respawns entries.
// Optional score accumulator enabled by defining SCROLL_SCORE_EN.
//
// state  | meaning
// IDLE   | waiting for loadplat or refresh_en
// LOAD   | writing initial layout, one entry per cycle
// SCROLL | shifting entries down by mag, one entry per cycle
// DONE   | trigger handshake, waiting for refresh_en to fall
module platform_scroller
    import doodle_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             loadplat,
    input  logic             refresh_en,
    input  logic [9:0]       plat_temp_Y,
    output logic [15:0][8:0] platX,
    output logic [15:0][8:0] platY,
    output logic             trigger,
    output logic             busy,
    output logic [15:0]      score
);

    scroll_state_t state, next_state;
    logic [3:0]    idx;
    logic [9:0]    mag;
    logic [9:0]    req_mag;
    logic [9:0]    neg_y;
    logic [9:0]    sum;
    logic [8:0]    respawn_x;
    logic [15:0]   lfsr;
    logic          last_idx;
    logic          start_scroll;

    plat_lfsr u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .out   (lfsr)
    );

    assign neg_y    = ~plat_temp_Y + 10'd1;
    assign req_mag  = !plat_temp_Y[9] ? 10'd0 :
                      (neg_y > 10'(MAX_SCROLL)) ? 10'(MAX_SCROLL) : neg_y;
    assign sum      = {1'b0, platY[idx]} + mag;
    // Bits 9:8 of the generator are deliberately skipped to keep X within 32..350.
    assign respawn_x = 9'(PLAT_X_MIN) + 9'(lfsr & 16'h00FF) + 9'(lfsr >> 10);
    assign last_idx  = (idx == 4'(NUM_PLAT - 1));
    assign start_scroll = (state == IDLE) && (next_state == SCROLL);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (loadplat)        next_state = LOAD;
                else if (refresh_en) next_state = SCROLL;
            end
            LOAD: begin
                if (last_idx) next_state = IDLE;
            end
            SCROLL: begin
                if (loadplat)      next_state = LOAD;
                else if (last_idx) next_state = DONE;
            end
            DONE: begin
                if (loadplat)         next_state = LOAD;
                else if (!refresh_en) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            idx     <= 4'd0;
            mag     <= 10'd0;
            trigger <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            busy    <= (next_state != IDLE);
            // Rises one cycle after DONE is reached; drops as soon as DONE is left.
            trigger <= (state == DONE) && (next_state == DONE);
            if (next_state != state)                     idx <= 4'd0;
            else if (state == LOAD || state == SCROLL)   idx <= idx + 4'd1;
            if (start_scroll) mag <= req_mag;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                platX[i] <= init_x(4'(i));
                platY[i] <= init_y(4'(i));
            end
        end else if (state == LOAD) begin
            platX[idx] <= init_x(idx);
            platY[idx] <= init_y(idx);
        end else if (state == SCROLL) begin
            if (sum >= 10'(Y_LIMIT)) begin
                platY[idx] <= 9'(sum - 10'(Y_LIMIT));
                platX[idx] <= respawn_x;
            end else begin
                platY[idx] <= sum[8:0];
            end
        end
    end

`ifdef SCROLL_SCORE_EN
    logic [16:0] score_sum;

    assign score_sum = {1'b0, score} + 17'(req_mag);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                                        score <= 16'h0;
        else if (next_state == LOAD && state != LOAD)     score <= 16'h0;
        else if (start_scroll)                            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
`else
    assign score = 16'h0;
`endif

endmodule

// File: tb/tb_platform_scroller.sv
// Self-checking bench for platform_scroller: transaction-level table model plus literal spot checks.
module tb_platform_scroller;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             loadplat = 1'b0;
    logic             refresh_en = 1'b0;
    logic [9:0]       plat_temp_Y = 10'd0;
    logic [15:0][8:0] platX;
    logic [15:0][8:0] platY;
    logic             trigger;
    logic             busy;
    logic [15:0]      score;

    int vectors = 0;
    int miscompares = 0;
    int cyc;
    int mx [16];
    int my [16];
    int mscore = 0;
    bit model_valid = 0;

    platform_scroller dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .loadplat    (loadplat),
        .refresh_en  (refresh_en),
        .plat_temp_Y (plat_temp_Y),
        .platX       (platX),
        .platY       (platY),
        .trigger     (trigger),
        .busy        (busy),
        .score       (score)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int k = 0; k < n; k++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 16; i++) begin
            mx[i] = 64 + 24 * i;
            my[i] = 464 - 29 * i;
        end
        mscore = 0;
    endtask

    // Table and score compared against the model on every idle cycle.
    always @(negedge Clk) begin
        if (model_valid && !Reset) begin
            int bad;
            bad = -1;
            for (int i = 15; i >= 0; i--)
                if (int'(platX[i]) != mx[i] || int'(platY[i]) != my[i]) bad = i;
            vectors++;
            if (bad >= 0) begin
                miscompares++;
                $display("FAIL table[%0d]: got x=%0d y=%0d expected x=%0d y=%0d",
                         bad, platX[bad], platY[bad], mx[bad], my[bad]);
            end else if (int'(score) != mscore) begin
                miscompares++;
                $display("FAIL score: got %0d expected %0d", score, mscore);
            end
        end
    end

    task automatic do_scroll(input logic [9:0] ty, input int hold);
        int c0, neg, m, s;
        logic [15:0] l;
        @(negedge Clk);
        model_valid = 0;
        c0 = cyc;
        refresh_en = 1'b1;
        plat_temp_Y = ty;
        neg = ty[9] ? 1024 - int'(ty) : 0;
        m = (neg > 63) ? 63 : neg;
        for (int i = 0; i < 16; i++) begin
            s = my[i] + m;
            if (s >= 480) begin
                l = lfsr_at(c0 + 1 + i);
                my[i] = s - 480;
                mx[i] = 32 + int'(l[7:0]) + int'(l[15:10]);
            end else begin
                my[i] = s;
            end
        end
`ifdef SCROLL_SCORE_EN
        mscore = (mscore + m > 65535) ? 65535 : mscore + m;
`endif
        for (int k = 0; k <= 17 + hold; k++) begin
            @(negedge Clk);
            chk("trigger_timing", int'(trigger), (k >= 17) ? 1 : 0);
            chk("busy_scroll", int'(busy), 1);
        end
        refresh_en = 1'b0;
        @(negedge Clk);
        chk("trigger_release", int'(trigger), 0);
        chk("busy_release", int'(busy), 0);
        model_valid = 1;
    endtask

    task automatic load_body();
        model_init();
        loadplat = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge Clk);
            if (k == 0) loadplat = 1'b0;
            chk("busy_load", int'(busy), (k < 16) ? 1 : 0);
            chk("trigger_load", int'(trigger), 0);
        end
        model_valid = 1;
    endtask

    task automatic do_load();
        @(negedge Clk);
        model_valid = 0;
        load_body();
    endtask

    task automatic do_abort();
        @(negedge Clk);
        model_valid = 0;
        refresh_en = 1'b1;
        plat_temp_Y = 10'h3E2;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            chk("trigger_abort", int'(trigger), 0);
        end
        refresh_en = 1'b0;
        load_body();
    endtask

    initial begin
        #22 Reset = 1'b0;
        model_init();
        @(negedge Clk);
        chk("reset_y0", int'(platY[0]), 464);
        chk("reset_y15", int'(platY[15]), 29);
        chk("reset_x15", int'(platX[15]), 424);
        chk("reset_trigger", int'(trigger), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_score", int'(score), 0);
        model_valid = 1;

        do_scroll(10'h3F6, 0);
        chk("m10_y0", int'(platY[0]), 474);
        chk("m10_y15", int'(platY[15]), 39);
        chk("m10_x0", int'(platX[0]), 64);

        do_load();
        do_scroll(10'h3EC, 0);
        chk("wrap_y0", int'(platY[0]), 4);
        chk("wrap_x0_range", (platX[0] >= 32 && platX[0] <= 350) ? 1 : 0, 1);
        chk("m20_y1", int'(platY[1]), 455);
        chk("m20_x1", int'(platX[1]), 88);

        do_scroll(10'h380, 0);
        chk("clamp_y15", int'(platY[15]), 112);
        chk("clamp_y2", int'(platY[2]), 9);
`ifdef SCROLL_SCORE_EN
        chk("clamp_score", int'(score), 83);
`else
        chk("score_tied", int'(score), 0);
`endif

        do_scroll(10'h005, 0);

        do_abort();
        chk("abort_y0", int'(platY[0]), 464);
        chk("abort_x15", int'(platX[15]), 424);
        chk("abort_score", int'(score), 0);

        do_scroll(10'h3F6, 10);
        chk("hold_y0", int'(platY[0]), 474);
        chk("hold_y15", int'(platY[15]), 39);

        repeat (3) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
